// File: rtl/data_mem_responder_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam int MAX_WAIT = 15;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response handshakes between the core and the responder.
interface data_mem_responder_if;
   import dmem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   mem_size_t   req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, alignment check and load extraction.
module mem_lane_align
   import dmem_pkg::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   input  logic        is_unsigned,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic        misaligned,
   output logic [31:0] load_data
);

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
   endfunction

   logic [31:0] shifted;
   assign shifted = rword >> {lane, 3'b000};

   always_comb begin
      byte_en    = 4'b0000;
      wdata_rep  = wdata;
      misaligned = 1'b0;
      load_data  = 32'h0;
      case (size)
         SZ_BYTE: begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            load_data = extend_byte(shifted[7:0], is_unsigned);
         end
         SZ_HALF: begin
            byte_en    = 4'b0011 << lane;
            wdata_rep  = {2{wdata[15:0]}};
            misaligned = lane[0];
            load_data  = extend_half(shifted[15:0], is_unsigned);
         end
         SZ_WORD: begin
            byte_en    = 4'b1111;
            misaligned = (lane != 2'b00);
            load_data  = rword;
         end
         default: begin
            byte_en = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states over a word RAM.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   dmem_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept, exec;

   logic        cap_we, cap_uns;
   logic [31:0] cap_addr, cap_wdata;
   mem_size_t   cap_size;

   logic        a_we, a_uns;
   logic [31:0] a_addr, a_wdata;
   mem_size_t   a_size;

   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             range_err, acc_err;
   logic [31:0]      mem_rd;
   logic [3:0]       byte_en;
   logic [31:0]      wdata_rep, load_data;
   logic             misaligned;

   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [31:0] mem [DEPTH_WORDS];

   assign accept = (state_q == IDLE) && bus.req_valid && reset;

   // With zero wait states the access happens on the accept edge, so live inputs feed it.
   always_comb begin
      if (state_q == IDLE) begin
         a_we    = bus.req_we;
         a_uns   = bus.req_unsigned;
         a_addr  = bus.req_addr;
         a_wdata = bus.req_wdata;
         a_size  = bus.req_size;
      end else begin
         a_we    = cap_we;
         a_uns   = cap_uns;
         a_addr  = cap_addr;
         a_wdata = cap_wdata;
         a_size  = cap_size;
      end
   end

   assign offset    = a_addr - BASE_ADDR;
   assign idx       = offset[IDX_W+1:2];
   assign range_err = (a_addr < BASE_ADDR) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
   assign acc_err   = (a_size == SZ_ILL) || misaligned || range_err;
   assign mem_rd    = mem[idx];

   mem_lane_align u_align (
      .size        (a_size),
      .lane        (offset[1:0]),
      .wdata       (a_wdata),
      .rword       (mem_rd),
      .is_unsigned (a_uns),
      .byte_en     (byte_en),
      .wdata_rep   (wdata_rep),
      .misaligned  (misaligned),
      .load_data   (load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  exec    = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               exec    = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (exec) begin
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || a_we) ? 32'h0 : load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cap_we    <= bus.req_we;
         cap_uns   <= bus.req_unsigned;
         cap_addr  <= bus.req_addr;
         cap_wdata <= bus.req_wdata;
         cap_size  <= bus.req_size;
      end
   end

   // RAM contents survive reset; exec can only fire out of reset.
   always_ff @(posedge clk) begin
      if (exec && a_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE) && reset;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table on a 1-wait instance plus latency, backpressure and reset sequences.
module tb_data_mem_responder;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [1:0]  req_size = 2'b10;
   int          sel = 1;
   int          checks = 0;
   int          errors = 0;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;

   always #5 clk = ~clk;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();
   data_mem_responder_if bus3 ();

   assign bus0.req_valid = req_valid && (sel == 0);
   assign bus0.req_we = req_we;
   assign bus0.req_addr = req_addr;
   assign bus0.req_wdata = req_wdata;
   assign bus0.req_size = mem_size_t'(req_size);
   assign bus0.req_unsigned = req_unsigned;
   assign bus0.rsp_ready = rsp_ready && (sel == 0);

   assign bus1.req_valid = req_valid && (sel == 1);
   assign bus1.req_we = req_we;
   assign bus1.req_addr = req_addr;
   assign bus1.req_wdata = req_wdata;
   assign bus1.req_size = mem_size_t'(req_size);
   assign bus1.req_unsigned = req_unsigned;
   assign bus1.rsp_ready = rsp_ready && (sel == 1);

   assign bus3.req_valid = req_valid && (sel == 3);
   assign bus3.req_we = req_we;
   assign bus3.req_addr = req_addr;
   assign bus3.req_wdata = req_wdata;
   assign bus3.req_size = mem_size_t'(req_size);
   assign bus3.req_unsigned = req_unsigned;
   assign bus3.rsp_ready = rsp_ready && (sel == 3);

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

   always_comb begin
      m_req_ready = bus1.req_ready;
      m_rsp_valid = bus1.rsp_valid;
      m_rsp_rdata = bus1.rsp_rdata;
      m_rsp_err   = bus1.rsp_err;
      case (sel)
         0: begin
            m_req_ready = bus0.req_ready;
            m_rsp_valid = bus0.rsp_valid;
            m_rsp_rdata = bus0.rsp_rdata;
            m_rsp_err   = bus0.rsp_err;
         end
         3: begin
            m_req_ready = bus3.req_ready;
            m_rsp_valid = bus3.rsp_valid;
            m_rsp_rdata = bus3.rsp_rdata;
            m_rsp_err   = bus3.rsp_err;
         end
         default: ;
      endcase
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the selected DUT idle; returns #1 after the response handshake edge.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] rdata, output logic err, output int lat);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = ~wdata;
      req_size = 2'b11; req_unsigned = ~uns;
      lat = 1;
      while (!m_rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = m_rsp_rdata;
      err   = m_rsp_err;
      if (!m_rsp_valid) lat = -1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0));
      vecs.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 32'h04, 32'h0,        2'b10, 0, 32'h0,        0));
      vecs.push_back(mk(1, 32'h05, 32'h123456AB, 2'b00, 0, 32'h0,        0));
      vecs.push_back(mk(0, 32'h05, 32'h0,        2'b00, 0, 32'hFFFFFFAB, 0));
      vecs.push_back(mk(0, 32'h05, 32'h0,        2'b00, 1, 32'h000000AB, 0));
      vecs.push_back(mk(0, 32'h04, 32'h0,        2'b10, 0, 32'h0000AB00, 0));
      vecs.push_back(mk(1, 32'h00, 32'h11223344, 2'b10, 0, 32'h0,        0));
      vecs.push_back(mk(1, 32'h03, 32'h0000FFFF, 2'b01, 0, 32'h0,        1));
      vecs.push_back(mk(0, 32'h00, 32'h0,        2'b10, 0, 32'h11223344, 0));
      vecs.push_back(mk(0, 32'h1000, 32'h0,      2'b10, 0, 32'h0,        1));
      vecs.push_back(mk(1, 32'h06, 32'h12348765, 2'b01, 0, 32'h0,        0));
      vecs.push_back(mk(0, 32'h06, 32'h0,        2'b01, 0, 32'hFFFF8765, 0));
      vecs.push_back(mk(0, 32'h06, 32'h0,        2'b01, 1, 32'h00008765, 0));
      vecs.push_back(mk(0, 32'h04, 32'h0,        2'b10, 0, 32'h8765AB00, 0));
      vecs.push_back(mk(0, 32'h08, 32'h0,        2'b11, 0, 32'h0,        1));
      vecs.push_back(mk(0, 32'h02, 32'h0,        2'b10, 0, 32'h0,        1));
      vecs.push_back(mk(0, 32'h07, 32'h0,        2'b00, 1, 32'h00000087, 0));
      vecs.push_back(mk(0, 32'h04, 32'h0,        2'b00, 0, 32'h00000000, 0));
      vecs.push_back(mk(0, 32'h10, 32'h0,        2'b10, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 32'h0FFC, 32'hA5A5A5A5, 2'b10, 0, 32'h0,      0));
      vecs.push_back(mk(0, 32'h0FFE, 32'h0,      2'b01, 0, 32'hFFFFA5A5, 0));

      sel = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_ready", {31'h0, m_req_ready}, 32'h0);
      chk("reset_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
      chk("reset_rsp_rdata", m_rsp_rdata, 32'h0);
      chk("reset_rsp_err",   {31'h0, m_rsp_err}, 32'h0);
      reset = 1'b1;
      #1;
      chk("post_reset_req_ready", {31'h0, m_req_ready}, 32'h1);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         chk($sformatf("vec%0d_req_ready", i), {31'h0, m_req_ready}, 32'h1);
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      end

      // Backpressure: response must hold while rsp_ready is low
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!m_rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd2);
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1;
         chk($sformatf("bp_rsp_valid_%0d", c), {31'h0, m_rsp_valid}, 32'h1);
         chk($sformatf("bp_rsp_rdata_%0d", c), m_rsp_rdata, 32'hDEADBEEF);
         chk($sformatf("bp_req_ready_%0d", c), {31'h0, m_req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("bp_rsp_valid_last", {31'h0, m_rsp_valid}, 32'h1);
      chk("bp_rsp_rdata_last", m_rsp_rdata, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_done_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
      chk("bp_done_req_ready", {31'h0, m_req_ready}, 32'h1);

      // Latency sweep on the zero- and three-wait instances
      sel = 0;
      do_req(1, 32'h40, 32'h5A5A0F0F, 2'b10, 0, rd, er, lat);
      chk("w0_store_latency", 32'(lat), 32'd1);
      do_req(0, 32'h40, 32'h0, 2'b10, 0, rd, er, lat);
      chk("w0_load_latency", 32'(lat), 32'd1);
      chk("w0_load_rdata", rd, 32'h5A5A0F0F);
      sel = 3;
      do_req(1, 32'h40, 32'hC3C3_1234, 2'b10, 0, rd, er, lat);
      chk("w3_store_latency", 32'(lat), 32'd4);
      do_req(0, 32'h42, 32'h0, 2'b01, 0, rd, er, lat);
      chk("w3_load_latency", 32'(lat), 32'd4);
      chk("w3_load_rdata", rd, 32'hFFFFC3C3);

      // Reset during WAIT abandons the pending store
      sel = 1;
      do_req(1, 32'h20, 32'hCAFEF00D, 2'b10, 0, rd, er, lat);
      do_req(0, 32'h20, 32'h0, 2'b10, 0, rd, er, lat);
      chk("rst_pre_load", rd, 32'hCAFEF00D);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_size = 2'b10; req_unsigned = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_req_ready", {31'h0, m_req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", m_rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'h0, m_rsp_err}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_after_req_ready", {31'h0, m_req_ready}, 32'h1);
      do_req(0, 32'h20, 32'h0, 2'b10, 0, rd, er, lat);
      chk("rst_after_load", rd, 32'hCAFEF00D);
      chk("rst_after_latency", 32'(lat), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
